// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative BTB.
// Counter encoding, entry layout and counter update.
package btb_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'b00;
  localparam cnt_t CNT_WNT = 2'b01;
  localparam cnt_t CNT_WT  = 2'b10;
  localparam cnt_t CNT_ST  = 2'b11;

  // Tag field is sized for the smallest index; unused upper bits stay zero.
  localparam int TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    cnt_t                 cnt;
  } btb_entry_t;

  function automatic cnt_t sat_update(cnt_t cnt, logic taken);
    cnt_t r;
    r = cnt;
    unique case (1'b1)
      taken && (cnt != CNT_ST):   r = cnt + 2'd1;
      !taken && (cnt != CNT_SNT): r = cnt - 2'd1;
      default:                    r = cnt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// IF-stage lookup and EX-stage update bundle for btb_assoc.
// slave is the BTB side, master the pipeline side.
interface btb_assoc_if;
  logic [31:0] pc;
  logic        hit;
  logic [31:0] target;
  logic        predicted_taken;
  logic        update;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        flush;

  modport master (
    output pc, update, update_pc,
    output update_target, update_taken, flush,
    input  hit, target, predicted_taken
  );

  modport slave (
    input  pc, update, update_pc,
    input  update_target, update_taken, flush,
    output hit, target, predicted_taken
  );
endinterface

// File: rtl/btb_plru.sv
// Tree pseudo-LRU state for one BTB set.
// Heap-ordered nodes; bit=0 points the victim at the lower half.
module btb_plru #(
  parameter  int NUM_WAYS = 2,
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim_way
);

  if (NUM_WAYS == 1) begin : g_none
    logic unused;
    assign unused     = ^{clk, rst, clr, touch, touch_way};
    assign victim_way = '0;
  end else begin : g_tree
    localparam int LVL = $clog2(NUM_WAYS);

    logic [NUM_WAYS-2:0] bits_q, bits_d;

    always_comb begin
      int node;
      node       = 0;
      victim_way = '0;
      for (int l = 0; l < LVL; l++) begin
        victim_way[LVL-1-l] = bits_q[node];
        node = 2*node + 1 + int'(bits_q[node]);
      end
    end

    always_comb begin
      int   node;
      logic d;
      bits_d = bits_q;
      node   = 0;
      d      = 1'b0;
      if (touch) begin
        for (int l = 0; l < LVL; l++) begin
          d            = touch_way[LVL-1-l];
          bits_d[node] = ~d;
          node         = 2*node + 1 + int'(d);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst || clr) bits_q <= '0;
      else            bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit counters
// and per-set tree pseudo-LRU replacement.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 2
) (
  input logic       clk,
  input logic       rst,
  btb_assoc_if.slave bus
);

  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = 30 - INDEX_W;
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  btb_entry_t tbl_q [NUM_SETS][NUM_WAYS];

  logic [INDEX_W-1:0]   l_set, u_set;
  logic [TAG_W-1:0]     l_tag_n, u_tag_n;
  logic [TAG_MAX_W-1:0] l_tag, u_tag;
  logic [NUM_WAYS-1:0]  l_match, u_match;

  assign l_set   = bus.pc[INDEX_W+1:2];
  assign l_tag_n = bus.pc[31:2+INDEX_W];
  assign l_tag   = TAG_MAX_W'(l_tag_n);
  assign u_set   = bus.update_pc[INDEX_W+1:2];
  assign u_tag_n = bus.update_pc[31:2+INDEX_W];
  assign u_tag   = TAG_MAX_W'(u_tag_n);

  // Lookup reads registered state only, so same-cycle updates stay invisible.
  always_comb begin
    logic [31:0] tgt;
    logic        pt;
    tgt = '0;
    pt  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      l_match[w] = tbl_q[l_set][w].valid && (tbl_q[l_set][w].tag == l_tag);
      if (l_match[w]) begin
        tgt = tgt | tbl_q[l_set][w].target;
        pt  = pt  | tbl_q[l_set][w].cnt[1];
      end
    end
    bus.hit             = |l_match;
    bus.target          = tgt;
    bus.predicted_taken = pt;
  end

  logic [WAY_W-1:0] victim [NUM_SETS];
  logic [WAY_W-1:0] hit_way, inv_way, wr_way;
  logic             u_hit, any_inv, upd_ok, wr_en;
  btb_entry_t       wr_d;

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      u_match[w] = tbl_q[u_set][w].valid && (tbl_q[u_set][w].tag == u_tag);
      if (u_match[w]) hit_way = WAY_W'(w);
      if (!tbl_q[u_set][w].valid) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
    u_hit  = |u_match;
    upd_ok = bus.update && !bus.flush && (bus.update_pc[1:0] == 2'b00);
    wr_en  = upd_ok && (u_hit || bus.update_taken);
    wr_way = u_hit ? hit_way : (any_inv ? inv_way : victim[u_set]);
    wr_d   = tbl_q[u_set][wr_way];
    if (u_hit) begin
      wr_d.cnt = sat_update(wr_d.cnt, bus.update_taken);
      if (bus.update_taken) wr_d.target = bus.update_target;
    end else begin
      wr_d.valid  = 1'b1;
      wr_d.tag    = u_tag;
      wr_d.target = bus.update_target;
      wr_d.cnt    = CNT_WT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          tbl_q[s][w].valid <= 1'b0;
    end else if (wr_en) begin
      tbl_q[u_set][wr_way] <= wr_d;
    end
  end

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    btb_plru #(.NUM_WAYS(NUM_WAYS)) u_plru (
      .clk        (clk),
      .rst        (rst),
      .clr        (bus.flush),
      .touch      (wr_en && (u_set == INDEX_W'(s))),
      .touch_way  (wr_way),
      .victim_way (victim[s])
    );
  end

  a_onehot_lookup: assert property (
    @(posedge clk) disable iff (rst) $onehot0(l_match));
  a_onehot_update: assert property (
    @(posedge clk) disable iff (rst) $onehot0(u_match));

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (8 sets, 2 ways).
// Table rows drive one cycle each; expected lookups go through a queue.
module tb_btb_assoc;

  typedef struct {
    logic [31:0] pc;
    logic        upd;
    logic [31:0] upc;
    logic [31:0] tgt;
    logic        tk;
    logic        fl;
    logic        rs;
    logic        chk;
    logic        eh;
    logic [31:0] et;
    logic        ep;
  } vec_t;

  typedef struct {
    int          row;
    logic        chk;
    logic        eh;
    logic [31:0] et;
    logic        ep;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t sb[$];

  btb_assoc_if bus ();

  btb_assoc #(.NUM_SETS(8), .NUM_WAYS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void add(
    logic [31:0] pc, logic upd, logic [31:0] upc, logic [31:0] tgt,
    logic tk, logic fl, logic rs, logic chk,
    logic eh, logic [31:0] et, logic ep);
    vec_t v;
    v.pc = pc; v.upd = upd; v.upc = upc; v.tgt = tgt; v.tk = tk;
    v.fl = fl; v.rs = rs; v.chk = chk; v.eh = eh; v.et = et; v.ep = ep;
    vecs.push_back(v);
  endfunction

  function automatic void look(logic [31:0] pc, logic eh,
                               logic [31:0] et, logic ep);
    add(pc, 0, 0, 0, 0, 0, 0, 1, eh, et, ep);
  endfunction

  function automatic void upd(logic [31:0] pc, logic [31:0] upc,
                              logic [31:0] tgt, logic tk, logic eh,
                              logic [31:0] et, logic ep);
    add(pc, 1, upc, tgt, tk, 0, 0, 1, eh, et, ep);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        checks++;
        if (bus.hit !== e.eh) begin
          errors++;
          $display("FAIL hit row %0d: got %b want %b", e.row, bus.hit, e.eh);
        end
        checks++;
        if (bus.target !== e.et) begin
          errors++;
          $display("FAIL target row %0d: got %h want %h",
                   e.row, bus.target, e.et);
        end
        checks++;
        if (bus.predicted_taken !== e.ep) begin
          errors++;
          $display("FAIL taken row %0d: got %b want %b",
                   e.row, bus.predicted_taken, e.ep);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.pc = '0; bus.update = 1'b0; bus.update_pc = '0;
    bus.update_target = '0; bus.update_taken = 1'b0; bus.flush = 1'b0;

    // reset and first allocation / counter walk
    add(32'h1000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    look(32'h1000, 0, 0, 0);
    upd(32'h1000, 32'h1000, 32'h2000, 1, 0, 0, 0);
    look(32'h1000, 1, 32'h2000, 1);
    upd(32'h1020, 32'h1000, 32'h0, 0, 0, 0, 0);
    upd(32'h1000, 32'h1000, 32'h0, 0, 1, 32'h2000, 0);
    upd(32'h1000, 32'h1000, 32'h2000, 1, 1, 32'h2000, 0);
    upd(32'h1000, 32'h1000, 32'h2000, 1, 1, 32'h2000, 0);
    upd(32'h1000, 32'h1000, 32'h2000, 1, 1, 32'h2000, 1);
    upd(32'h1000, 32'h1000, 32'h3000, 1, 1, 32'h2000, 1);
    upd(32'h1000, 32'h1000, 32'h0, 0, 1, 32'h3000, 1);
    upd(32'h1000, 32'h1202, 32'h5000, 1, 1, 32'h3000, 1);
    upd(32'h1200, 32'h1400, 32'h6000, 0, 0, 0, 0);
    look(32'h1400, 0, 0, 0);
    look(32'h1000, 1, 32'h3000, 1);
    add(32'h1000, 0, 0, 0, 0, 1, 0, 1, 1, 32'h3000, 1);
    look(32'h1000, 0, 0, 0);
    // PLRU replacement in set 0
    upd(32'h1000, 32'h1000, 32'hA000, 1, 0, 0, 0);
    upd(32'h1000, 32'h1020, 32'hA020, 1, 1, 32'hA000, 1);
    upd(32'h1000, 32'h1040, 32'hA040, 1, 1, 32'hA000, 1);
    look(32'h1000, 0, 0, 0);
    look(32'h1020, 1, 32'hA020, 1);
    look(32'h1040, 1, 32'hA040, 1);
    upd(32'h1040, 32'h1020, 32'hA120, 1, 1, 32'hA040, 1);
    upd(32'h1020, 32'h1060, 32'hA060, 1, 1, 32'hA120, 1);
    look(32'h1040, 0, 0, 0);
    look(32'h1020, 1, 32'hA120, 1);
    look(32'h1060, 1, 32'hA060, 1);
    // no bypass on same-cycle update
    upd(32'h1080, 32'h1080, 32'hB080, 1, 0, 0, 0);
    look(32'h1080, 1, 32'hB080, 1);
    // fill, then flush with a dropped update
    upd(32'h1004, 32'h1004, 32'hC004, 1, 0, 0, 0);
    upd(32'h1004, 32'h1008, 32'hC008, 1, 1, 32'hC004, 1);
    upd(32'h1008, 32'h100C, 32'hC00C, 1, 1, 32'hC008, 1);
    upd(32'h100C, 32'h1010, 32'hC010, 1, 1, 32'hC00C, 1);
    add(32'h1010, 1, 32'h10A0, 32'hD0A0, 1, 1, 0, 1, 1, 32'hC010, 1);
    look(32'h1004, 0, 0, 0);
    look(32'h1008, 0, 0, 0);
    look(32'h100C, 0, 0, 0);
    look(32'h1010, 0, 0, 0);
    look(32'h10A0, 0, 0, 0);
    look(32'h1080, 0, 0, 0);
    // reset mid-sequence beats a concurrent update
    upd(32'h1004, 32'h1004, 32'hC004, 1, 0, 0, 0);
    add(32'h1004, 1, 32'h1008, 32'hC008, 1, 0, 1, 1, 1, 32'hC004, 1);
    look(32'h1004, 0, 0, 0);
    look(32'h1008, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      rst               = vecs[i].rs;
      bus.pc            = vecs[i].pc;
      bus.update        = vecs[i].upd;
      bus.update_pc     = vecs[i].upc;
      bus.update_target = vecs[i].tgt;
      bus.update_taken  = vecs[i].tk;
      bus.flush         = vecs[i].fl;
      e.row = i; e.chk = vecs[i].chk;
      e.eh = vecs[i].eh; e.et = vecs[i].et; e.ep = vecs[i].ep;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; bus.update = 1'b0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
